shake256_arbiter: RTL and testbench



---
 rtl/shake256_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_shake256_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake256_arbiter.sv
// Round-robin arbiter sharing one SHAKE-256 core among NREQ requesters.
// Define SHAKE_ARB_TIMEOUT_EN to build the WAIT watchdog (abort after TIMEOUT_CYC cycles).
module shake256_arbiter #(
    parameter int NREQ        = 3,
    parameter int IDW         = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*512-1:0] req_msg,
    input  logic [NREQ*2-1:0]   req_mode,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic [1535:0]       rsp_data,
    output logic                busy,
    output logic                timeout_flag,
    output logic [511:0]        core_M,
    output logic                core_active,
    output logic [1:0]          core_n_num,
    input  logic                core_finish,
    input  logic [1535:0]       core_Z
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT_CYC < 1) begin : g_param_check
        $error("shake256_arbiter: illegal parameter combination");
    end

    logic [1:0]          state_r;
    logic [IDW-1:0]      ptr_r;
    logic [IDW-1:0]      owner_r;
    logic                err_r;
    logic [1535:0]       rsp_data_r;
    logic [511:0]        core_m_r;
    logic [1:0]          core_n_num_r;
    logic [NREQ-1:0]     gnt_r;
    logic [NREQ-1:0]     done_r;
    logic                core_active_r;

`ifdef SHAKE_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0]      tmo_cnt_r;
    logic                timeout_flag_r;
`endif

    logic                found_s;
    logic [IDW-1:0]      sel_s;
    int                  cand_s;
    logic [NREQ-1:0]     req_bits_s;
    logic [NREQ*512-1:0] msg_shift_s;
    logic [NREQ*2-1:0]   mode_shift_s;
    logic [511:0]        sel_msg_s;
    logic [1:0]          sel_mode_s;

    function automatic logic [NREQ-1:0] owner_onehot(input logic [IDW-1:0] idx);
        owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin pick: first pending request strictly after ptr_r, with wrap-around.
    always_comb begin
        found_s    = 1'b0;
        sel_s      = '0;
        cand_s     = 0;
        req_bits_s = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s     = (int'(ptr_r) + k) % NREQ;
            req_bits_s = req >> cand_s;
            if (!found_s && req_bits_s[0]) begin
                found_s = 1'b1;
                sel_s   = IDW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
        msg_shift_s  = req_msg >> {sel_s, 9'd0};
        mode_shift_s = req_mode >> {sel_s, 1'b0};
        sel_msg_s    = msg_shift_s[511:0];
        sel_mode_s   = mode_shift_s[1:0];
    end

    // Control FSM; every output is a register updated on the transition into its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ptr_r         <= IDW'(NREQ - 1);
            owner_r       <= '0;
            err_r         <= 1'b0;
            rsp_data_r    <= '0;
            core_m_r      <= '0;
            core_n_num_r  <= 2'd0;
            gnt_r         <= '0;
            done_r        <= '0;
            core_active_r <= 1'b0;
`ifdef SHAKE_ARB_TIMEOUT_EN
            tmo_cnt_r      <= '0;
            timeout_flag_r <= 1'b0;
`endif
        end else begin
            gnt_r         <= '0;
            done_r        <= '0;
            core_active_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        owner_r <= sel_s;
                        gnt_r   <= owner_onehot(sel_s);
                        if (sel_mode_s == 2'd0) begin
                            // Illegal mode skips the core and reports straight away.
                            err_r   <= 1'b1;
                            done_r  <= owner_onehot(sel_s);
                            state_r <= ST_DONE;
                        end else begin
                            err_r         <= 1'b0;
                            core_m_r      <= sel_msg_s;
                            core_n_num_r  <= sel_mode_s;
                            core_active_r <= 1'b1;
                            state_r       <= ST_LAUNCH;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
`ifdef SHAKE_ARB_TIMEOUT_EN
                    tmo_cnt_r <= '0;
`endif
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_finish) begin
                        rsp_data_r <= core_Z;
                        err_r      <= 1'b0;
                        done_r     <= owner_onehot(owner_r);
                        state_r    <= ST_DONE;
`ifdef SHAKE_ARB_TIMEOUT_EN
                    end else if (tmo_cnt_r == TCW'(TIMEOUT_CYC - 1)) begin
                        err_r          <= 1'b1;
                        timeout_flag_r <= 1'b1;
                        done_r         <= owner_onehot(owner_r);
                        state_r        <= ST_DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TCW'(1);
                        state_r   <= ST_WAIT;
`else
                    end else begin
                        state_r <= ST_WAIT;
`endif
                    end
                end
                ST_DONE: begin
                    ptr_r   <= owner_r;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt         = gnt_r;
    assign done        = done_r;
    assign err         = err_r;
    assign rsp_data    = rsp_data_r;
    assign busy        = (state_r != ST_IDLE);
    assign core_M      = core_m_r;
    assign core_active = core_active_r;
    assign core_n_num  = core_n_num_r;

`ifdef SHAKE_ARB_TIMEOUT_EN
    assign timeout_flag = timeout_flag_r;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_shake256_arbiter.sv
// Scoreboard bench for shake256_arbiter: directed requests, stub core, queue-based monitor.
// Exercises the watchdog path when SHAKE_ARB_TIMEOUT_EN is defined.
module tb_shake256_arbiter;

    localparam int NREQ = 3;
`ifdef SHAKE_ARB_TIMEOUT_EN
    localparam int TCYC = 20;
`else
    localparam int TCYC = 1023;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*512-1:0] req_msg;
    logic [NREQ*2-1:0]   req_mode;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                err;
    logic [1535:0]       rsp_data;
    logic                busy;
    logic                timeout_flag;
    logic [511:0]        core_M;
    logic                core_active;
    logic [1:0]          core_n_num;
    logic                core_finish;
    logic [1535:0]       core_Z;

    shake256_arbiter #(.NREQ(NREQ), .IDW(3), .TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_msg(req_msg), .req_mode(req_mode),
        .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data), .busy(busy),
        .timeout_flag(timeout_flag), .core_M(core_M), .core_active(core_active),
        .core_n_num(core_n_num), .core_finish(core_finish), .core_Z(core_Z)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NREQ-1:0] vec;
        logic            act;
        logic [1:0]      mode;
        logic [511:0]    msg;
    } gexp_t;
    typedef struct {
        logic [NREQ-1:0] vec;
        logic            err;
        logic [1535:0]   data;
    } dexp_t;

    gexp_t         gq[$];
    dexp_t         dq[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [1535:0] exp_last = '0;
    int            fin_cyc = 0;
    int            stub_cnt = 0;
    int            stub_lat = 3;
    logic          stub_hang = 1'b0;
    logic          stub_spurious = 1'b0;

    logic [511:0] m0 = {16{32'hDEAD_BEEF}};
    logic [511:0] m1 = {8{64'h0123_4567_89AB_CDEF}};
    logic [511:0] m2 = {32{16'h5A3C}};
    logic [511:0] m_one = 512'd1;

    function automatic logic [1535:0] z_model(input logic [511:0] m, input logic [1:0] md);
        return {m ^ {256{md}}, ~m, m};
    endfunction

    task automatic chk(input string name, input logic [1535:0] act, input logic [1535:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic set_slot(input int i, input logic [1:0] md, input logic [511:0] m);
        req_msg[512*i +: 512] = m;
        req_mode[2*i +: 2]    = md;
    endtask

    task automatic push_op(input int i, input logic [1:0] md, input logic [511:0] m);
        gexp_t g;
        dexp_t d;
        g.vec = 3'b001 << i; g.act = (md != 2'd0); g.mode = md; g.msg = m;
        d.vec = 3'b001 << i; d.err = (md == 2'd0);
        if (md != 2'd0) exp_last = z_model(m, md);
        d.data = exp_last;
        gq.push_back(g);
        dq.push_back(d);
    endtask

    task automatic wait_gnts(input int n, input int budget);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (gnt != '0) seen++;
        end
        chk("gnt_count_in_budget", seen, n);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((busy || gq.size() != 0 || dq.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("idle_in_budget", (t < budget), 1'b1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, gnt, '0);
        chk({tag, "_done"}, done, '0);
        chk({tag, "_err"}, err, '0);
        chk({tag, "_rsp"}, rsp_data, '0);
        chk({tag, "_busy"}, busy, '0);
        chk({tag, "_tflag"}, timeout_flag, '0);
        chk({tag, "_core_M"}, core_M, '0);
        chk({tag, "_core_active"}, core_active, '0);
        chk({tag, "_core_n_num"}, core_n_num, '0);
    endtask

    // Stub core: finishes stub_lat cycles after core_active with a model-derived output.
    initial begin
        core_finish = 1'b0;
        core_Z      = '0;
        forever begin
            @(negedge clk);
            core_finish = 1'b0;
            if (rst) begin
                stub_cnt = 0;
            end else if (stub_spurious) begin
                stub_spurious = 1'b0;
                core_finish   = 1'b1;
                core_Z        = {48{32'hBAD0_BAD0}};
            end else if (core_active) begin
                stub_cnt = stub_lat;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0 && !stub_hang) begin
                    core_finish = 1'b1;
                    core_Z      = z_model(core_M, core_n_num);
                    fin_cyc     = cyc;
                end
            end
        end
    end

    // Monitor: pops expected grants and completions whenever the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt != '0) begin
                    if (gq.size() == 0) begin
                        chk("gnt_unexpected", gnt, '0);
                    end else begin
                        gexp_t g;
                        g = gq.pop_front();
                        chk("gnt", gnt, g.vec);
                        chk("core_active", core_active, g.act);
                        if (g.act) begin
                            chk("core_n_num", core_n_num, g.mode);
                            chk("core_M", core_M, g.msg);
                        end
                    end
                end else if (core_active) begin
                    chk("core_active_without_gnt", core_active, 1'b0);
                end
                if (done != '0) begin
                    if (dq.size() == 0) begin
                        chk("done_unexpected", done, '0);
                    end else begin
                        dexp_t d;
                        d = dq.pop_front();
                        chk("done", done, d.vec);
                        chk("err", err, d.err);
                        chk("rsp_data", rsp_data, d.data);
                        if (!d.err) chk("done_latency", cyc, fin_cyc + 1);
                    end
                end else if (err) begin
                    chk("err_without_done", err, 1'b0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SHAKE_ARB_TIMEOUT_EN
        int a;
        int t;
`endif
        rst = 1'b1; req = '0; req_msg = '0; req_mode = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Concurrent requests from reset pointer: order 0,1,2,0.
        set_slot(0, 2'd1, m0); set_slot(1, 2'd2, m1); set_slot(2, 2'd3, m2);
        push_op(0, 2'd1, m0); push_op(1, 2'd2, m1); push_op(2, 2'd3, m2); push_op(0, 2'd1, m0);
        req = 3'b111;
        wait_gnts(4, 200);
        req = '0;
        wait_idle(100);

        // Single KDF: grant visible one cycle after req.
        set_slot(0, 2'd3, m_one);
        push_op(0, 2'd3, m_one);
        req = 3'b001;
        @(negedge clk);
        chk("kdf_gnt_latency", gnt, 3'b001);
        req = '0;
        wait_idle(50);
        chk("kdf_rsp_low", rsp_data[255:0], m_one[255:0]);

        // Illegal mode: gnt and done together, err set, data unchanged.
        set_slot(1, 2'd0, m2);
        push_op(1, 2'd0, m2);
        req = 3'b010;
        wait_gnts(1, 20);
        req = '0;
        wait_idle(20);

        // A stray core_finish in IDLE must be ignored.
        stub_spurious = 1'b1;
        repeat (4) @(negedge clk);
        chk("spurious_rsp", rsp_data, exp_last);
        chk("spurious_busy", busy, 1'b0);

        // Fairness: req0 held, req1 arrives mid-operation and wins next.
        set_slot(0, 2'd1, m1); set_slot(1, 2'd2, m0);
        push_op(0, 2'd1, m1); push_op(1, 2'd2, m0); push_op(0, 2'd1, m1);
        req = 3'b001;
        wait_gnts(1, 20);
        req = 3'b011;
        wait_gnts(1, 50);
        req = 3'b001;
        wait_gnts(1, 50);
        req = '0;
        wait_idle(50);

        // Reset ten cycles into WAIT: no done, everything cleared.
        begin
            gexp_t g;
            g.vec = 3'b001; g.act = 1'b1; g.mode = 2'd2; g.msg = m2;
            gq.push_back(g);
        end
        set_slot(0, 2'd2, m2);
        stub_hang = 1'b1;
        req = 3'b001;
        wait_gnts(1, 20);
        req = '0;
        repeat (10) @(negedge clk);
        chk("hang_busy", busy, 1'b1);
        chk("hang_tflag", timeout_flag, 1'b0);
        rst = 1'b1;
        #1;
        check_zero("midwait_rst");
        @(negedge clk);
        rst = 1'b0;
        stub_hang = 1'b0;
        exp_last = '0;
        set_slot(2, 2'd3, m1);
        push_op(2, 2'd3, m1);
        req = 3'b100;
        wait_gnts(1, 20);
        req = '0;
        wait_idle(50);

`ifdef SHAKE_ARB_TIMEOUT_EN
        // Watchdog: core never finishes, abort twenty cycles into WAIT.
        begin
            gexp_t g;
            dexp_t d;
            g.vec = 3'b001; g.act = 1'b1; g.mode = 2'd1; g.msg = m0;
            d.vec = 3'b001; d.err = 1'b1; d.data = exp_last;
            gq.push_back(g);
            dq.push_back(d);
        end
        set_slot(0, 2'd1, m0);
        stub_hang = 1'b1;
        req = 3'b001;
        wait_gnts(1, 20);
        a = cyc;
        req = '0;
        t = 0;
        while (done == '0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_latency", cyc - a, 21);
        chk("timeout_flag_set", timeout_flag, 1'b1);
        repeat (5) @(negedge clk);
        chk("timeout_flag_sticky", timeout_flag, 1'b1);
        stub_hang = 1'b0;
        set_slot(1, 2'd2, m2);
        push_op(1, 2'd2, m2);
        req = 3'b010;
        wait_gnts(1, 20);
        req = '0;
        wait_idle(50);
        chk("timeout_flag_after_ok", timeout_flag, 1'b1);
        rst = 1'b1;
        #1;
        chk("timeout_flag_cleared", timeout_flag, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_last = '0;
`endif

        repeat (3) @(negedge clk);
        chk("gq_drained", gq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
